// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: the two requester ports, the shared read data, the slave-side
// request/response and the grant indicator. The arbiter uses the master modport.
// The slave modport is the view of everything around it: the requesters and the memory slave.
interface mem_bus_arbiter_if #(
  parameter int AW = 32
) ();
  // Requester 0 (CPU datapath)
  logic          m0_valid;
  logic [AW-1:0] m0_addr;
  logic [31:0]   m0_wdata;
  logic [3:0]    m0_wstrb;
  logic          m0_lock;
  logic          m0_ready;
  logic          m0_err;
  // Requester 1 (DMA / peripheral master)
  logic          m1_valid;
  logic [AW-1:0] m1_addr;
  logic [31:0]   m1_wdata;
  logic [3:0]    m1_wstrb;
  logic          m1_lock;
  logic          m1_ready;
  logic          m1_err;
  // Read data returned to whichever port gets the ready pulse
  logic [31:0]   m_rdata;
  // Memory slave side
  logic          s_valid;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata;
  logic [3:0]    s_wstrb;
  logic [31:0]   s_rdata;
  logic          s_ready;
  // Owner of the current or most recent transfer
  logic          grant_id;

  modport master (
    input  m0_valid, m0_addr, m0_wdata, m0_wstrb, m0_lock,
    output m0_ready, m0_err,
    input  m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_lock,
    output m1_ready, m1_err,
    output m_rdata,
    output s_valid, s_addr, s_wdata, s_wstrb,
    input  s_rdata, s_ready,
    output grant_id
  );

  modport slave (
    output m0_valid, m0_addr, m0_wdata, m0_wstrb, m0_lock,
    input  m0_ready, m0_err,
    output m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_lock,
    input  m1_ready, m1_err,
    input  m_rdata,
    input  s_valid, s_addr, s_wdata, s_wstrb,
    output s_rdata, s_ready,
    input  grant_id
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory slave port between the CPU (port 0) and a DMA master
// (port 1). Round-robin arbitration with a lock that keeps an AMO load/store pair together.
// A watchdog completes a stuck transfer with an error, and it releases a lock that is
// held without any request. Completion (mX_ready/mX_err/m_rdata) is combinational in
// the cycle the slave answers. Everything else comes from registers.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int AW      = 32
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.master bus
);

  // Timer is wide enough to hold TIMEOUT; a disabled watchdog still keeps a 1-bit counter.
  localparam int            TW          = (TIMEOUT > 32'sd0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic          WDOG_EN     = (TIMEOUT > 32'sd0);
  localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT);
  localparam logic [TW-1:0] TIMER_MAX   = {TW{1'b1}};
  localparam logic [TW-1:0] TIMER_ONE   = TW'(32'd1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_grant_id;
  logic            r_rr_ptr;
  logic            r_s_valid;
  logic [AW-1:0]   r_s_addr;
  logic [31:0]     r_s_wdata;
  logic [3:0]      r_s_wstrb;
  logic [TW-1:0]   r_timer;

  logic            w_gnt_valid;
  logic            w_gnt_lock;
  logic            w_timeout;
  logic            w_capture;
  logic            w_cap_port;
  logic            w_done_ok;
  logic            w_done_err;
  logic            w_rr_update;
  logic [AW-1:0]   w_cap_addr;
  logic [31:0]     w_cap_wdata;
  logic [3:0]      w_cap_wstrb;

  // The watchdog fires when the timer has counted TIMEOUT cycles in BUSY or LOCKED.
  assign w_timeout = WDOG_EN && (r_timer == TIMER_LIMIT);

  // Select the request/lock lines of the port that currently owns the grant.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_lock  = 1'b0;
    if (r_grant_id) begin
      w_gnt_valid = bus.m1_valid;
      w_gnt_lock  = bus.m1_lock;
    end else begin
      w_gnt_valid = bus.m0_valid;
      w_gnt_lock  = bus.m0_lock;
    end
  end

  // Select the request fields of the port being granted this cycle.
  always_comb begin
    w_cap_addr  = {AW{1'b0}};
    w_cap_wdata = 32'h0000_0000;
    w_cap_wstrb = 4'h0;
    if (w_cap_port) begin
      w_cap_addr  = bus.m1_addr;
      w_cap_wdata = bus.m1_wdata;
      w_cap_wstrb = bus.m1_wstrb;
    end else begin
      w_cap_addr  = bus.m0_addr;
      w_cap_wdata = bus.m0_wdata;
      w_cap_wstrb = bus.m0_wstrb;
    end
  end

  // Next-state logic: arbitration, completion and lock handling.
  // Reset suppresses every action, so an in-flight response is never reported.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_cap_port   = r_grant_id;
    w_done_ok    = 1'b0;
    w_done_err   = 1'b0;
    w_rr_update  = 1'b0;
    if (reset) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.m0_valid && bus.m1_valid) begin
            w_capture    = 1'b1;
            w_cap_port   = r_rr_ptr;
            w_state_next = ST_BUSY;
          end else if (bus.m0_valid) begin
            w_capture    = 1'b1;
            w_cap_port   = 1'b0;
            w_state_next = ST_BUSY;
          end else if (bus.m1_valid) begin
            w_capture    = 1'b1;
            w_cap_port   = 1'b1;
            w_state_next = ST_BUSY;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
        ST_BUSY: begin
          // A slave answer in the same cycle as the watchdog limit is a normal completion.
          if (bus.s_ready) begin
            w_done_ok = 1'b1;
            if (w_gnt_lock) begin
              w_state_next = ST_LOCKED;
            end else begin
              w_state_next = ST_IDLE;
              w_rr_update  = 1'b1;
            end
          end else if (w_timeout) begin
            w_done_err   = 1'b1;
            w_state_next = ST_IDLE;
            w_rr_update  = 1'b1;
          end else begin
            w_state_next = ST_BUSY;
          end
        end
        ST_LOCKED: begin
          // The other port is ignored until the owner leaves the lock or it expires.
          if (w_gnt_valid) begin
            w_capture    = 1'b1;
            w_cap_port   = r_grant_id;
            w_state_next = ST_BUSY;
          end else if (!w_gnt_lock) begin
            w_state_next = ST_IDLE;
            w_rr_update  = 1'b1;
          end else if (w_timeout) begin
            w_state_next = ST_IDLE;
            w_rr_update  = 1'b1;
          end else begin
            w_state_next = ST_LOCKED;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Grant owner and round-robin pointer; the pointer moves away from the last owner on release.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant_id <= 1'b0;
      r_rr_ptr   <= 1'b0;
    end else begin
      if (w_capture) begin
        r_grant_id <= w_cap_port;
      end
      if (w_rr_update) begin
        r_rr_ptr <= ~r_grant_id;
      end
    end
  end

  // Slave request registers: fields captured at grant and held stable until completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s_valid <= 1'b0;
      r_s_addr  <= {AW{1'b0}};
      r_s_wdata <= 32'h0000_0000;
      r_s_wstrb <= 4'h0;
    end else if (w_capture) begin
      r_s_valid <= 1'b1;
      r_s_addr  <= w_cap_addr;
      r_s_wdata <= w_cap_wdata;
      r_s_wstrb <= w_cap_wstrb;
    end else if (w_done_ok || w_done_err) begin
      r_s_valid <= 1'b0;
    end
  end

  // Watchdog timer: cleared on every state change, counts in BUSY/LOCKED, saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= {TW{1'b0}};
    end else if (w_state_next != r_state) begin
      r_timer <= {TW{1'b0}};
    end else if ((r_state != ST_IDLE) && (r_timer != TIMER_MAX)) begin
      r_timer <= r_timer + TIMER_ONE;
    end
  end

  // Completion goes only to the owning port, so both ready pulses can never be high together.
  assign bus.m0_ready = (w_done_ok | w_done_err) & ~r_grant_id;
  assign bus.m1_ready = (w_done_ok | w_done_err) &  r_grant_id;
  assign bus.m0_err   = w_done_err & ~r_grant_id;
  assign bus.m1_err   = w_done_err &  r_grant_id;
  assign bus.m_rdata  = w_done_ok ? bus.s_rdata : 32'h0000_0000;

  assign bus.s_valid  = r_s_valid;
  assign bus.s_addr   = r_s_addr;
  assign bus.s_wdata  = r_s_wdata;
  assign bus.s_wstrb  = r_s_wstrb;
  assign bus.grant_id = r_grant_id;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios for the two-port memory arbiter with hand-computed
// expectations. Inputs change 1 ns after the rising edge, and outputs are sampled on the falling edge.
module tb_mem_bus_arbiter;
  localparam int AW      = 32;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  mem_bus_arbiter_if #(.AW(AW)) bus ();

  mem_bus_arbiter #(.TIMEOUT(TIMEOUT), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.m0_valid = 1'b0; bus.m0_addr = 32'h0; bus.m0_wdata = 32'h0; bus.m0_wstrb = 4'h0; bus.m0_lock = 1'b0;
    bus.m1_valid = 1'b0; bus.m1_addr = 32'h0; bus.m1_wdata = 32'h0; bus.m1_wstrb = 4'h0; bus.m1_lock = 1'b0;
    bus.s_rdata  = 32'h0; bus.s_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic exp_id;

    // Reset state
    do_reset();
    sample();
    check_eq("rst_s_valid", {31'd0, bus.s_valid}, 32'd0);
    check_eq("rst_grant", {31'd0, bus.grant_id}, 32'd0);
    check_eq("rst_ready", {30'd0, bus.m0_ready, bus.m1_ready}, 32'd0);
    check_eq("rst_err", {30'd0, bus.m0_err, bus.m1_err}, 32'd0);
    check_eq("rst_rdata", bus.m_rdata, 32'd0);
    check_eq("rst_s_addr", bus.s_addr, 32'd0);

    // T1: single m0 read, slave answers two cycles after s_valid
    step();
    bus.m0_valid = 1'b1; bus.m0_addr = 32'h0000_0100; bus.m0_wstrb = 4'h0;
    sample();
    check_eq("t1_sv_arb_cycle", {31'd0, bus.s_valid}, 32'd0);
    step();
    sample();
    check_eq("t1_sv_busy", {31'd0, bus.s_valid}, 32'd1);
    check_eq("t1_s_addr", bus.s_addr, 32'h0000_0100);
    check_eq("t1_grant", {31'd0, bus.grant_id}, 32'd0);
    check_eq("t1_no_rdy_b0", {31'd0, bus.m0_ready}, 32'd0);
    step();
    sample();
    check_eq("t1_no_rdy_b1", {31'd0, bus.m0_ready}, 32'd0);
    step();
    bus.s_ready = 1'b1; bus.s_rdata = 32'hDEAD_BEEF;
    sample();
    check_eq("t1_m0_ready", {31'd0, bus.m0_ready}, 32'd1);
    check_eq("t1_m0_err", {31'd0, bus.m0_err}, 32'd0);
    check_eq("t1_rdata", bus.m_rdata, 32'hDEAD_BEEF);
    check_eq("t1_m1_ready", {31'd0, bus.m1_ready}, 32'd0);
    step();
    bus.s_ready = 1'b0; bus.m0_valid = 1'b0;
    sample();
    check_eq("t1_sv_drop", {31'd0, bus.s_valid}, 32'd0);
    check_eq("t1_rdy_once", {31'd0, bus.m0_ready}, 32'd0);

    // T2: simultaneous requests alternate 0,1,0,1 starting from reset
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus.m0_valid = 1'b1; bus.m0_addr = 32'h0000_0200;
      bus.m1_valid = 1'b1; bus.m1_addr = 32'h0000_0300;
      step();
      exp_id = (k % 2 == 1);
      bus.s_ready = 1'b1; bus.s_rdata = 32'h0000_00A0 + 32'(k);
      sample();
      check_eq("t2_grant", {31'd0, bus.grant_id}, {31'd0, exp_id});
      check_eq("t2_s_addr", bus.s_addr, exp_id ? 32'h0000_0300 : 32'h0000_0200);
      check_eq("t2_rdy_win", {31'd0, exp_id ? bus.m1_ready : bus.m0_ready}, 32'd1);
      check_eq("t2_rdy_wait", {31'd0, exp_id ? bus.m0_ready : bus.m1_ready}, 32'd0);
      check_eq("t2_rdata", bus.m_rdata, 32'h0000_00A0 + 32'(k));
      step();
      bus.s_ready = 1'b0; bus.m0_valid = 1'b0; bus.m1_valid = 1'b0;
      sample();
      check_eq("t2_sv_idle", {31'd0, bus.s_valid}, 32'd0);
      step();
    end

    // T3: locked m0 read then m0 write; m1 waits until the write completes
    do_reset();
    bus.m0_valid = 1'b1; bus.m0_lock = 1'b1; bus.m0_addr = 32'h0000_0400; bus.m0_wstrb = 4'h0;
    bus.m1_valid = 1'b1; bus.m1_addr = 32'h0000_0500;
    step();
    bus.s_ready = 1'b1; bus.s_rdata = 32'h0000_0011;
    sample();
    check_eq("t3_rd_grant", {31'd0, bus.grant_id}, 32'd0);
    check_eq("t3_rd_ready", {30'd0, bus.m0_ready, bus.m1_ready}, 32'd2);
    step();
    bus.s_ready = 1'b0; bus.m0_valid = 1'b0;
    sample();
    check_eq("t3_locked_sv", {31'd0, bus.s_valid}, 32'd0);
    check_eq("t3_locked_gid", {31'd0, bus.grant_id}, 32'd0);
    step();
    bus.m0_valid = 1'b1; bus.m0_lock = 1'b0; bus.m0_wstrb = 4'hF; bus.m0_wdata = 32'h0000_0005;
    sample();
    check_eq("t3_m1_ignored", {31'd0, bus.s_valid}, 32'd0);
    step();
    sample();
    check_eq("t3_wr_grant", {31'd0, bus.grant_id}, 32'd0);
    check_eq("t3_wr_wdata", bus.s_wdata, 32'h0000_0005);
    check_eq("t3_wr_wstrb", {28'd0, bus.s_wstrb}, 32'h0000_000F);
    step();
    bus.s_ready = 1'b1;
    sample();
    check_eq("t3_wr_ready", {30'd0, bus.m0_ready, bus.m1_ready}, 32'd2);
    step();
    bus.s_ready = 1'b0; bus.m0_valid = 1'b0; bus.m0_wstrb = 4'h0;
    sample();
    check_eq("t3_arb_sv", {31'd0, bus.s_valid}, 32'd0);
    step();
    sample();
    check_eq("t3_m1_grant", {31'd0, bus.grant_id}, 32'd1);
    check_eq("t3_m1_addr", bus.s_addr, 32'h0000_0500);
    step();
    bus.s_ready = 1'b1;
    sample();
    check_eq("t3_m1_ready", {30'd0, bus.m0_ready, bus.m1_ready}, 32'd1);
    step();
    bus.s_ready = 1'b0; bus.m1_valid = 1'b0;

    // T4: slave silent, watchdog completes on BUSY cycle index 8; then ready/timeout tie
    do_reset();
    bus.m0_valid = 1'b1; bus.m0_addr = 32'h0000_0600;
    bus.m1_valid = 1'b1; bus.m1_addr = 32'h0000_0700;
    bus.s_rdata  = 32'hFFFF_FFFF;
    step();
    for (int i = 0; i < 8; i++) begin
      sample();
      check_eq("t4_wait", {30'd0, bus.m0_ready, bus.m0_err}, 32'd0);
      step();
    end
    sample();
    check_eq("t4_to_ready", {31'd0, bus.m0_ready}, 32'd1);
    check_eq("t4_to_err", {31'd0, bus.m0_err}, 32'd1);
    check_eq("t4_to_rdata", bus.m_rdata, 32'd0);
    check_eq("t4_m1_wait", {31'd0, bus.m1_ready}, 32'd0);
    step();
    bus.m0_valid = 1'b0;
    sample();
    check_eq("t4_idle_sv", {31'd0, bus.s_valid}, 32'd0);
    step();
    sample();
    check_eq("t4_m1_grant", {31'd0, bus.grant_id}, 32'd1);
    check_eq("t4_m1_sv", {31'd0, bus.s_valid}, 32'd1);
    repeat (8) step();
    bus.s_ready = 1'b1; bus.s_rdata = 32'h0000_0077;
    sample();
    check_eq("t4_tie_ready", {31'd0, bus.m1_ready}, 32'd1);
    check_eq("t4_tie_err", {31'd0, bus.m1_err}, 32'd0);
    check_eq("t4_tie_rdata", bus.m_rdata, 32'h0000_0077);
    step();
    bus.s_ready = 1'b0; bus.m1_valid = 1'b0;

    // T5: reset in BUSY together with s_ready
    do_reset();
    bus.m1_valid = 1'b1; bus.m1_addr = 32'h0000_0800;
    step();
    sample();
    check_eq("t5_m1_grant", {31'd0, bus.grant_id}, 32'd1);
    step();
    reset = 1'b1; bus.s_ready = 1'b1; bus.s_rdata = 32'h0000_1234;
    sample();
    check_eq("t5_no_ready", {30'd0, bus.m0_ready, bus.m1_ready}, 32'd0);
    step();
    reset = 1'b0; bus.s_ready = 1'b0; bus.m1_valid = 1'b0;
    sample();
    check_eq("t5_sv_off", {31'd0, bus.s_valid}, 32'd0);
    check_eq("t5_gid_zero", {31'd0, bus.grant_id}, 32'd0);
    step();
    bus.m0_valid = 1'b1; bus.m0_addr = 32'h0000_0900;
    step();
    bus.s_ready = 1'b1; bus.s_rdata = 32'h0000_CAFE;
    sample();
    check_eq("t5_next_addr", bus.s_addr, 32'h0000_0900);
    check_eq("t5_next_ready", {30'd0, bus.m0_ready, bus.m1_ready}, 32'd2);
    check_eq("t5_next_rdata", bus.m_rdata, 32'h0000_CAFE);
    step();
    bus.s_ready = 1'b0; bus.m0_valid = 1'b0;

    // T6: lock held with no request expires after TIMEOUT cycles, m1 then granted
    do_reset();
    bus.m0_valid = 1'b1; bus.m0_lock = 1'b1; bus.m0_addr = 32'h0000_0A00;
    bus.m1_valid = 1'b1; bus.m1_addr = 32'h0000_0B00;
    step();
    bus.s_ready = 1'b1; bus.s_rdata = 32'h0000_0022;
    sample();
    check_eq("t6_rd_ready", {30'd0, bus.m0_ready, bus.m1_ready}, 32'd2);
    step();
    bus.s_ready = 1'b0; bus.m0_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      sample();
      check_eq("t6_held", {28'd0, bus.m0_ready, bus.m0_err, bus.m1_ready, bus.s_valid}, 32'd0);
      step();
    end
    sample();
    check_eq("t6_release_sv", {31'd0, bus.s_valid}, 32'd0);
    step();
    bus.m0_lock = 1'b0;
    sample();
    check_eq("t6_m1_grant", {31'd0, bus.grant_id}, 32'd1);
    check_eq("t6_m1_addr", bus.s_addr, 32'h0000_0B00);
    step();
    bus.s_ready = 1'b1;
    sample();
    check_eq("t6_m1_ready", {28'd0, bus.m0_ready, bus.m0_err, bus.m1_ready, bus.m1_err}, 32'd2);
    step();
    bus.s_ready = 1'b0; bus.m1_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
